// File: rtl/wu_memory.sv
// rtl/wu_memory.sv - WU instruction store with fixed-latency read pipeline, output FIFO and stall generation
module wu_memory #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 4096,
  parameter int RD_LAT      = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int STALL_SLACK = 4
) (
  input  logic              clk,
  input  logic              reset_poweron_n,
  input  logic              wuf__wum__read,
  input  logic [ADDR_W-1:0] wuf__wum__addr,
  output logic              wum__wuf__stall,
  input  logic              mcntl__wum__write,
  input  logic [ADDR_W-1:0] mcntl__wum__addr,
  input  logic [DATA_W-1:0] mcntl__wum__wdata,
  output logic              wum__wud__valid,
  output logic [DATA_W-1:0] wum__wud__data,
  input  logic              wud__wum__ready,
  output logic              wum__mcntl__overflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(FIFO_DEPTH - STALL_SLACK);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FULLW, S_ERR} state_t;

  // ---------------------------------------------------------------- array
  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_in_range;
  logic              wr_in_range;
  logic [DATA_W-1:0] rd_data;

  assign rd_in_range = {1'b0, wuf__wum__addr} < DEPTH_C;
  assign wr_in_range = {1'b0, mcntl__wum__addr} < DEPTH_C;
  // Out-of-range reads return zero but still flow through the pipeline normally
  assign rd_data = rd_in_range ? mem[wuf__wum__addr[IDX_W-1:0]] : '0;

  // Manager write port; contents survive reset, and a same-cycle read sees the old word
  always_ff @(posedge clk) begin
    if (mcntl__wum__write && wr_in_range) begin
      mem[mcntl__wum__addr[IDX_W-1:0]] <= mcntl__wum__wdata;
    end
  end

  // ---------------------------------------------------------------- read pipeline
  logic              push_vld;
  logic [DATA_W-1:0] push_data;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_next;

  if (RD_LAT == 1) begin : g_lat1
    assign push_vld      = wuf__wum__read;
    assign push_data     = rd_data;
    assign inflight      = '0;
    assign inflight_next = '0;
  end else begin : g_pipe
    logic [RD_LAT-2:0] vld;
    logic [DATA_W-1:0] dat [RD_LAT-1];

    // Shift accepted reads toward the FIFO, one stage per cycle
    always_ff @(posedge clk or negedge reset_poweron_n) begin
      if (!reset_poweron_n) begin
        vld <= '0;
        for (int i = 0; i < RD_LAT - 1; i++) dat[i] <= '0;
      end else begin
        vld[0] <= wuf__wum__read;
        dat[0] <= rd_data;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          vld[i] <= vld[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end

    // Count reads currently travelling through the pipeline
    always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT - 1; i++) inflight = inflight + CNT_W'(vld[i]);
    end

    assign push_vld      = vld[RD_LAT-2];
    assign push_data     = dat[RD_LAT-2];
    assign inflight_next = inflight - CNT_W'(vld[RD_LAT-2]) + CNT_W'(wuf__wum__read);
  end

  // ---------------------------------------------------------------- output FIFO
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  occ_next;
  logic              stall_q;
  state_t            state;
  state_t            state_next;

  assign pop        = (count != '0) && wud__wum__ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok    = push_vld && ((count != FULL_C) || pop);
  assign drop       = push_vld && (count == FULL_C) && !pop;
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop);
  assign occ        = count + inflight;
  assign occ_next   = count_next + inflight_next;

  // FIFO storage needs no reset; the head is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the registered stall towards fetch
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      stall_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      stall_q <= occ_next >= THR_C;
    end
  end

  // ---------------------------------------------------------------- control FSM
  // State register
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) state <= S_IDLE;
    else                  state <= state_next;
  end

  // Next-state: an overflow from any state is terminal until reset
  always_comb begin
    state_next = state;
    if (drop) begin
      state_next = S_ERR;
    end else begin
      case (state)
        S_IDLE:   if (wuf__wum__read) state_next = S_ACTIVE;
        S_ACTIVE: begin
          if (stall_q)                                  state_next = S_FULLW;
          else if ((occ == '0) && !wuf__wum__read)      state_next = S_IDLE;
        end
        S_FULLW:  if (!stall_q) state_next = S_ACTIVE;
        default:  state_next = S_ERR;
      endcase
    end
  end

  // Outputs: sticky overflow is the ERR state; head data is zero while empty
  always_comb begin
    wum__mcntl__overflow = (state == S_ERR);
    wum__wuf__stall      = stall_q;
    wum__wud__valid      = (count != '0);
    wum__wud__data       = (count != '0) ? fifo_mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_wu_memory.sv
// tb/tb_wu_memory.sv - scoreboard bench for wu_memory with randomized traffic
module tb_wu_memory;
  localparam int AW  = 12;
  localparam int DW  = 64;
  localparam int DEP = 1024;
  localparam int RL  = 2;
  localparam int FD  = 8;
  localparam int SS  = 4;

  logic          clk;
  logic          rst_n;
  logic          read;
  logic [AW-1:0] raddr;
  logic          stall;
  logic          write;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  int beats = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mm [DEP];
  logic [DW-1:0] mon_e;
  logic h0, h1, h2;

  wu_memory #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .RD_LAT(RL), .FIFO_DEPTH(FD), .STALL_SLACK(SS)
  ) dut (
    .clk                 (clk),
    .reset_poweron_n     (rst_n),
    .wuf__wum__read      (read),
    .wuf__wum__addr      (raddr),
    .wum__wuf__stall     (stall),
    .mcntl__wum__write   (write),
    .mcntl__wum__addr    (waddr),
    .mcntl__wum__wdata   (wdata),
    .wum__wud__valid     (valid),
    .wum__wud__data      (data),
    .wud__wum__ready     (ready),
    .wum__mcntl__overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return (int'(a) < DEP) ? mm[a] : '0;
  endfunction

  // Monitor: every accepted head word must be the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none", data);
      end else begin
        mon_e = exp_q.pop_front();
        check("fifo_data", data, mon_e);
      end
    end
  end

  // One bus cycle: expected read data is taken before the same-cycle write lands
  task automatic cyc(input logic rd, input logic [AW-1:0] ra, input logic wr,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic keep);
    read  = rd;
    raddr = ra;
    write = wr;
    waddr = wa;
    wdata = wd;
    if (rd && keep) exp_q.push_back(model_read(ra));
    if (wr && int'(wa) < DEP) mm[wa] = wd;
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic drain(input string name);
    ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !valid) break;
      idle(1);
    end
    check({"drain_", name}, DW'(exp_q.size()), '0);
  endtask

  // Fetch-unit emulation: a read may issue only if stall was low three cycles ago
  task automatic fetch_step(input logic want, input logic [AW-1:0] a, output logic issued);
    logic cur;
    cur = stall;
    issued = want && !h2;
    h2 = h1;
    h1 = h0;
    h0 = cur;
    cyc(issued, a, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    int b0;
    int issued;
    logic iss;
    logic stall_seen;
    logic ovf_seen;
    rst_n = 1'b0; read = 0; raddr = '0; write = 0; waddr = '0; wdata = '0; ready = 0;
    h0 = 0; h1 = 0; h2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", DW'(valid), '0);
    check("rst_stall", DW'(stall), '0);
    check("rst_overflow", DW'(overflow), '0);
    check("rst_data", data, '0);
    rst_n = 1'b1;
    idle(2);

    // Program load
    for (int i = 0; i < DEP; i++) cyc(1'b0, '0, 1'b1, AW'(i), DW'(32'h100 + i), 1'b0);

    // Back-to-back reads with the decoder always ready
    ready = 1'b1;
    cyc(1'b1, 12'd0, 1'b0, '0, '0, 1'b1);
    check("lat_valid_t1", DW'(valid), '0);
    cyc(1'b1, 12'd1, 1'b0, '0, '0, 1'b1);
    check("lat_valid_t2", DW'(valid), 1);
    check("lat_data_t2", data, 64'h100);
    cyc(1'b1, 12'd2, 1'b0, '0, '0, 1'b1);
    check("seq_stall", DW'(stall), '0);
    cyc(1'b1, 12'd3, 1'b0, '0, '0, 1'b1);
    check("seq_stall2", DW'(stall), '0);
    drain("seq");

    // Stall flow control: decoder blocked, fetch honours stall with 3-cycle lag
    ready = 1'b0;
    issued = 0;
    stall_seen = 0;
    ovf_seen = 0;
    for (int c = 0; c < 300 && issued < 16; c++) begin
      if (c == 20) ready = 1'b1;
      if (stall) stall_seen = 1;
      fetch_step(1'b1, AW'(issued), iss);
      if (iss) issued++;
      if (overflow) ovf_seen = 1;
    end
    check("stall_issued", DW'(issued), 16);
    check("stall_seen", DW'(stall_seen), 1);
    check("stall_no_overflow", DW'(ovf_seen), '0);
    drain("stall");
    idle(2);
    check("stall_released", DW'(stall), '0);

    // Same-cycle write and read return old data; the next read sees the new word
    ready = 1'b1;
    b0 = beats;
    cyc(1'b1, 12'd5, 1'b1, 12'd5, 64'hDEAD, 1'b1);
    cyc(1'b1, 12'd5, 1'b0, '0, '0, 1'b1);
    drain("rw");
    check("rw_beats", DW'(beats - b0), 2);

    // Out-of-range read returns zero with no error
    b0 = beats;
    cyc(1'b1, 12'd1024, 1'b0, '0, '0, 1'b1);
    cyc(1'b1, 12'd4095, 1'b0, '0, '0, 1'b1);
    drain("oor");
    check("oor_beats", DW'(beats - b0), 2);
    check("oor_overflow", DW'(overflow), '0);

    // Overflow: stall ignored, only the first FD words survive
    ready = 1'b0;
    b0 = beats;
    for (int i = 0; i < 12; i++) cyc(1'b1, AW'(i), 1'b0, '0, '0, (i < FD) ? 1'b1 : 1'b0);
    idle(3);
    check("ovf_set", DW'(overflow), 1);
    check("ovf_valid", DW'(valid), 1);
    check("ovf_stall", DW'(stall), 1);
    drain("ovf");
    check("ovf_beats", DW'(beats - b0), FD);
    check("ovf_sticky", DW'(overflow), 1);

    // Asynchronous reset with words queued and a read in flight
    ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b1, AW'(20 + i), 1'b0, '0, '0, 1'b1);
    check("pre_rst_stall", DW'(stall), 1);
    check("pre_rst_valid", DW'(valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", DW'(valid), '0);
    check("mid_rst_stall", DW'(stall), '0);
    check("mid_rst_overflow", DW'(overflow), '0);
    check("mid_rst_data", data, '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    h0 = 0; h1 = 0; h2 = 0;
    ready = 1'b1;
    b0 = beats;
    idle(8);
    check("post_rst_valid", DW'(valid), '0);
    check("post_rst_beats", DW'(beats - b0), '0);

    // Randomized traffic against the array model
    for (int c = 0; c < 500; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        write = 1'b1;
        waddr = AW'($urandom_range(0, DEP + 20));
        wdata = {$urandom, $urandom};
      end
      read  = 1'b0;
      begin
        logic want;
        logic [AW-1:0] a;
        logic cur;
        want = ($urandom_range(0, 4) != 0);
        a    = AW'($urandom_range(0, DEP + 40));
        cur  = stall;
        iss  = want && !h2;
        h2 = h1; h1 = h0; h0 = cur;
        cyc(iss, a, write, waddr, wdata, 1'b1);
      end
      if (overflow) ovf_seen = 1;
    end
    check("rand_no_overflow", DW'(ovf_seen), '0);
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
